// File: rtl/clk_switch_ctrl.sv
// Clock-source switch sequencer.
// Accepts a source request through a valid/ready handshake. It then asks the
// core to quiesce, gates the core clock and moves the mux select while the
// clock is gated. After the settle time it ungates the clock and issues a
// core reset pulse. Every output is registered and driven from the FSM.
module clk_switch_ctrl #(
    parameter logic [1:0] RESET_SEL       = 2'b00,
    parameter int         GATE_CYCLES     = 4,
    parameter int         SETTLE_CYCLES   = 16,
    parameter int         RST_CYCLES      = 8,
    parameter int         QUIESCE_TIMEOUT = 255,
    parameter int         CNT_W           = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       req_valid_i,
    input  logic [1:0] req_sel_i,
    output logic       req_ready_o,
    output logic       quiesce_req_o,
    input  logic       quiesce_ack_i,
    output logic       clk_en_o,
    output logic [1:0] clk_sel_o,
    output logic       core_reset_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    // Terminal counts. A phase of N cycles ends when the counter, cleared on
    // entry to that phase, reaches N-1.
    localparam logic [CNT_W-1:0] GATE_LAST    = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(QUIESCE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_QUIESCE,
        S_GATE,
        S_SWITCH,
        S_SETTLE,
        S_RSTP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       target_q, target_d;
    logic [1:0]       clk_sel_q, clk_sel_d;
    logic             clk_en_q, clk_en_d;
    logic             core_reset_q, core_reset_d;
    logic             quiesce_req_q, quiesce_req_d;
    logic             req_ready_q, req_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             req_accept;

    // Saturating increment so a long wait can never wrap the counter.
    always_comb begin
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    // Handshake completes on an edge where both valid and ready are high.
    always_comb begin
        req_accept = req_valid_i & req_ready_q;
    end

    // Next-state and next-output logic for the switch sequence.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        target_d      = target_q;
        clk_sel_d     = clk_sel_q;
        clk_en_d      = clk_en_q;
        core_reset_d  = core_reset_q;
        quiesce_req_d = quiesce_req_q;
        req_ready_d   = req_ready_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = 1'b0;

        case (state_q)
            // Hold the core in reset for a fixed time after power-up.
            S_INIT: begin
                if (cnt_q == RST_LAST) begin
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                    core_reset_d = 1'b0;
                    req_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            // Wait for a request; a request for the current source is
            // acknowledged without touching the clock.
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_accept) begin
                    target_d = req_sel_i;
                    if (req_sel_i == clk_sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d       = S_QUIESCE;
                        cnt_d         = '0;
                        req_ready_d   = 1'b0;
                        quiesce_req_d = 1'b1;
                        busy_d        = 1'b1;
                    end
                end
            end

            // Wait for the core to drain. ACK takes priority over the
            // timeout when both land on the same cycle.
            S_QUIESCE: begin
                if (quiesce_ack_i) begin
                    state_d  = S_GATE;
                    cnt_d    = '0;
                    clk_en_d = 1'b0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d       = S_IDLE;
                    cnt_d         = '0;
                    quiesce_req_d = 1'b0;
                    err_d         = 1'b1;
                    req_ready_d   = 1'b1;
                    busy_d        = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            // Clock is gated; let the gate propagate before moving the mux.
            S_GATE: begin
                if (cnt_q == GATE_LAST) begin
                    state_d = S_SWITCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            // Single cycle: the select moves here, strictly while gated.
            S_SWITCH: begin
                state_d   = S_SETTLE;
                cnt_d     = '0;
                clk_sel_d = target_q;
            end

            // Give the new source time to settle, then ungate into reset.
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d      = S_RSTP;
                    cnt_d        = '0;
                    clk_en_d     = 1'b1;
                    core_reset_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            // Core reset pulse on the new clock, then report completion.
            S_RSTP: begin
                if (cnt_q == RST_LAST) begin
                    state_d       = S_IDLE;
                    cnt_d         = '0;
                    core_reset_d  = 1'b0;
                    quiesce_req_d = 1'b0;
                    done_d        = 1'b1;
                    req_ready_d   = 1'b1;
                    busy_d        = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            // Unreachable encodings recover through the power-up path.
            default: begin
                state_d       = S_INIT;
                cnt_d         = '0;
                clk_en_d      = 1'b1;
                core_reset_d  = 1'b1;
                quiesce_req_d = 1'b0;
                req_ready_d   = 1'b0;
                busy_d        = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset forces the safe power-up values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_INIT;
            cnt_q         <= '0;
            target_q      <= RESET_SEL;
            clk_sel_q     <= RESET_SEL;
            clk_en_q      <= 1'b1;
            core_reset_q  <= 1'b1;
            quiesce_req_q <= 1'b0;
            req_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            target_q      <= target_d;
            clk_sel_q     <= clk_sel_d;
            clk_en_q      <= clk_en_d;
            core_reset_q  <= core_reset_d;
            quiesce_req_q <= quiesce_req_d;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign req_ready_o   = req_ready_q;
    assign quiesce_req_o = quiesce_req_q;
    assign clk_en_o      = clk_en_q;
    assign clk_sel_o     = clk_sel_q;
    assign core_reset_o  = core_reset_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: directed requests, scoreboarded DONE/ERR events
// plus per-cycle checks of the sequencing outputs.
module tb_clk_switch_ctrl;

    localparam int G = 4;
    localparam int S = 16;
    localparam int R = 8;
    localparam int TO = 255;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       req_valid_i;
    logic [1:0] req_sel_i;
    logic       req_ready_o;
    logic       quiesce_req_o;
    logic       quiesce_ack_i;
    logic       clk_en_o;
    logic [1:0] clk_sel_o;
    logic       core_reset_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct packed {
        logic       is_err;
        int         cyc;
        logic [1:0] sel;
    } exp_t;

    exp_t sb_q[$];

    clk_switch_ctrl dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .req_valid_i   (req_valid_i),
        .req_sel_i     (req_sel_i),
        .req_ready_o   (req_ready_o),
        .quiesce_req_o (quiesce_req_o),
        .quiesce_ack_i (quiesce_ack_i),
        .clk_en_o      (clk_en_o),
        .clk_sel_o     (clk_sel_o),
        .core_reset_o  (core_reset_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every DONE/ERR pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset_i && (done_o || err_o)) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_event", int'({done_o, err_o}), 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("sb_kind{done,err}", int'({done_o, err_o}),
                         e.is_err ? 1 : 2);
                check_eq("sb_cycle", cyc, e.cyc);
                check_eq("sb_clk_sel", int'(clk_sel_o), int'(e.sel));
            end
        end
    end

    // Expected {clk_en, clk_sel, core_reset, quiesce_req, busy} at cycle j
    // after acceptance, with ACK first sampled on edge k.
    function automatic logic [5:0] seq_exp(input int j, input int k,
                                           input logic [1:0] o, input logic [1:0] n);
        int sw;
        int ub;
        int dn;
        sw = k + G + 1;
        ub = sw + S;
        dn = ub + R;
        seq_exp = {!(j >= k && j < ub), (j >= sw) ? n : o,
                   (j >= ub && j < dn), (j < dn), (j < dn)};
    endfunction

    function automatic logic [5:0] out_vec();
        out_vec = {clk_en_o, clk_sel_o, core_reset_o, quiesce_req_o, busy_o};
    endfunction

    // Core reset held R cycles after reset release, then idle and ready.
    task automatic init_check();
        for (int k = 1; k <= R; k++) begin
            @(negedge clk);
            check_eq($sformatf("init_core_reset k=%0d", k), int'(core_reset_o),
                     (k < R) ? 1 : 0);
        end
        check_eq("init_ready", int'(req_ready_o), 1);
        check_eq("init_busy", int'(busy_o), 0);
        check_eq("init_clk_en", int'(clk_en_o), 1);
        check_eq("init_clk_sel", int'(clk_sel_o), 0);
    endtask

    // Called at a negedge; returns at the negedge right after acceptance.
    task automatic issue(input logic [1:0] sel, input bit push, input bit is_err,
                         input int offset, input logic [1:0] exp_sel);
        int n;
        req_valid_i = 1'b1;
        req_sel_i   = sel;
        n = 0;
        while (!req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            check_eq("req_ready_wait", int'(req_ready_o), 1);
            req_valid_i = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (push) sb_q.push_back('{is_err, cyc + offset, exp_sel});
            @(negedge clk);
            req_valid_i = 1'b0;
        end
    endtask

    // Track a full switch from the negedge after acceptance up to DONE.
    task automatic run_seq(input int k, input int drop_j,
                           input logic [1:0] o, input logic [1:0] n);
        int dn;
        dn = k + G + 1 + S + R;
        for (int j = 0; j <= dn; j++) begin
            if (j > 0) @(negedge clk);
            check_eq($sformatf("seq_vec j=%0d", j), int'(out_vec()),
                     int'(seq_exp(j, k, o, n)));
            if (j == k - 1) quiesce_ack_i = 1'b1;
            if (j == drop_j) quiesce_ack_i = 1'b0;
        end
        check_eq("seq_ready_after_done", int'(req_ready_o), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i       = 1'b1;
        req_valid_i   = 1'b0;
        req_sel_i     = 2'b00;
        quiesce_ack_i = 1'b0;

        // Power-up
        repeat (5) @(negedge clk);
        check_eq("rst_vec", int'(out_vec()), int'(6'b1_00_1_0_1));
        check_eq("rst_ready", int'(req_ready_o), 0);
        check_eq("rst_pulses", int'({done_o, err_o}), 0);
        reset_i = 1'b0;
        init_check();

        // Same-source request: DONE next cycle, nothing toggles
        issue(2'b00, 1'b1, 1'b0, 0, 2'b00);
        check_eq("same_vec", int'(out_vec()), int'(6'b1_00_0_0_0));
        check_eq("same_ready", int'(req_ready_o), 1);
        @(negedge clk);
        check_eq("same_vec_after", int'(out_vec()), int'(6'b1_00_0_0_0));

        // Timeout with ACK held low
        issue(2'b10, 1'b1, 1'b1, TO, 2'b00);
        for (int j = 0; j <= TO; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 0 || j >= TO - 1)
                check_eq($sformatf("to_vec j=%0d", j), int'(out_vec()),
                         int'({1'b1, 2'b00, 1'b0, j < TO, j < TO}));
        end
        check_eq("to_ready", int'(req_ready_o), 1);

        // Switch 00 -> 01 with ACK tied high
        quiesce_ack_i = 1'b1;
        issue(2'b01, 1'b1, 1'b0, 1 + G + 1 + S + R, 2'b01);
        run_seq(1, -1, 2'b00, 2'b01);

        // Late ACK (edge 20), dropped again during SETTLE: 01 -> 11
        quiesce_ack_i = 1'b0;
        issue(2'b11, 1'b1, 1'b0, 20 + G + 1 + S + R, 2'b11);
        run_seq(20, 20 + G + 1 + 5, 2'b01, 2'b11);

        // Reset asserted during SETTLE
        quiesce_ack_i = 1'b1;
        issue(2'b10, 1'b0, 1'b0, 0, 2'b10);
        repeat (10) @(negedge clk);
        check_eq("settle_clk_sel", int'(clk_sel_o), 2);
        check_eq("settle_clk_en", int'(clk_en_o), 0);
        reset_i = 1'b1;
        #1;
        check_eq("midrst_vec", int'(out_vec()), int'(6'b1_00_1_0_1));
        check_eq("midrst_ready", int'(req_ready_o), 0);
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        init_check();

        repeat (5) @(negedge clk);
        check_eq("sb_pending", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
